// File: rtl/nf10_nic_opl_pkg.sv
// Shared encodings and port helpers for the NIC output port lookup.
// Port fields are 8-bit one-hot: MAC i at bit 2i, DMA i at bit 2i+1.
package nf10_nic_opl_pkg;

    localparam int PORT_W = 8;

    localparam logic [1:0] MODE_NIC  = 2'd0;
    localparam logic [1:0] MODE_LOOP = 2'd1;
    localparam logic [1:0] MODE_DROP = 2'd2;

    localparam logic [1:0] ST_HEAD = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    typedef logic [PORT_W-1:0] port_t;

    // MAC (even bit) goes to its DMA partner, DMA (odd bit) to its MAC
    function automatic port_t map_nic_port(input port_t src);
        if ((src & 8'h55) != 8'h00)
            return src << 1;
        else
            return src >> 1;
    endfunction

    // one-hot and inside the populated port range
    function automatic logic src_valid(input port_t src,
                                       input int num_ports);
        logic [2*PORT_W-1:0] wide;
        wide = {{PORT_W{1'b0}}, src};
        return (src != '0) &&
               ((src & (src - 8'd1)) == '0) &&
               ((wide >> (2*num_ports)) == '0);
    endfunction

endpackage

// File: rtl/nf10_axis_reg_slice.sv
// One-deep AXI4-Stream register stage.
// Accepts a new beat whenever the register is empty or being drained.
module nf10_axis_reg_slice #(
    parameter int C_DATA_WIDTH  = 256,
    parameter int C_TUSER_WIDTH = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [C_DATA_WIDTH-1:0]     s_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]   s_tstrb,
    input  logic [C_TUSER_WIDTH-1:0]    s_tuser,
    input  logic                        s_tlast,
    input  logic                        s_tvalid,
    output logic                        s_tready,
    output logic [C_DATA_WIDTH-1:0]     m_tdata,
    output logic [C_DATA_WIDTH/8-1:0]   m_tstrb,
    output logic [C_TUSER_WIDTH-1:0]    m_tuser,
    output logic                        m_tlast,
    output logic                        m_tvalid,
    input  logic                        m_tready
);

    assign s_tready = !m_tvalid || m_tready;

    // load on accept, empty once the held beat is taken downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tdata  <= '0;
            m_tstrb  <= '0;
            m_tuser  <= '0;
        end else if (s_tvalid && s_tready) begin
            m_tvalid <= 1'b1;
            m_tlast  <= s_tlast;
            m_tdata  <= s_tdata;
            m_tstrb  <= s_tstrb;
            m_tuser  <= s_tuser;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/nf10_nic_opl_multi.sv
// NIC output port lookup: stamps the destination port on each packet
// head, drops bad-source packets and keeps forward/drop counters.
module nf10_nic_opl_multi
    import nf10_nic_opl_pkg::*;
#(
    parameter int C_DATA_WIDTH  = 256,
    parameter int C_TUSER_WIDTH = 128,
    parameter int C_NUM_PORTS   = 4,
    parameter int C_SRC_POS     = 16,
    parameter int C_DST_POS     = 24,
    parameter int C_CNT_WIDTH   = 32
) (
    input  logic                        axi_aclk,
    input  logic                        axi_reset,
    input  logic [C_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]   s_axis_tstrb,
    input  logic [C_TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    output logic [C_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic [C_TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    input  logic [1:0]                  mode,
    input  logic                        cnt_clr,
    output logic [C_CNT_WIDTH-1:0]      pkt_fwd_cnt,
    output logic [C_CNT_WIDTH-1:0]      pkt_drop_cnt
);

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic                     slice_ready;
    port_t                    src;
    port_t                    dst;
    logic                     head_fwd;
    logic                     xfer;
    logic                     emit;
    logic                     fwd_inc;
    logic                     drop_inc;
    logic [C_TUSER_WIDTH-1:0] user_mod;

    assign src = s_axis_tuser[C_SRC_POS +: PORT_W];

    // head decision from the current mode and source port
    always_comb begin
        head_fwd = 1'b0;
        dst      = '0;
        if (src_valid(src, C_NUM_PORTS)) begin
            unique case (mode)
                MODE_NIC: begin
                    head_fwd = 1'b1;
                    dst      = map_nic_port(src);
                end
                MODE_LOOP: begin
                    head_fwd = 1'b1;
                    dst      = src;
                end
                default: begin
                    head_fwd = 1'b0;
                    dst      = '0;
                end
            endcase
        end
    end

    // a dropping packet is sunk without waiting on the master side
    assign s_axis_tready = (state == ST_DROP) ? 1'b1 : slice_ready;
    assign xfer          = s_axis_tvalid && s_axis_tready;

    assign emit = xfer &&
                  ((state == ST_PASS) ||
                   ((state == ST_HEAD) && head_fwd));

    assign fwd_inc  = xfer && s_axis_tlast &&
                      ((state == ST_PASS) ||
                       ((state == ST_HEAD) && head_fwd));
    assign drop_inc = xfer && s_axis_tlast &&
                      ((state == ST_DROP) ||
                       ((state == ST_HEAD) && !head_fwd));

    // only the head beat carries a rewritten destination field
    always_comb begin
        user_mod = s_axis_tuser;
        if (state == ST_HEAD)
            user_mod[C_DST_POS +: PORT_W] = dst;
    end

    // packet framing: choose pass or drop on the head beat
    always_comb begin
        state_nxt = state;
        if (xfer) begin
            if (s_axis_tlast)
                state_nxt = ST_HEAD;
            else if (state == ST_HEAD)
                state_nxt = head_fwd ? ST_PASS : ST_DROP;
        end
        if (state != ST_HEAD && state != ST_PASS && state != ST_DROP)
            state_nxt = ST_HEAD;
    end

    // state register
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset)
            state <= ST_HEAD;
        else
            state <= state_nxt;
    end

    // saturating counters, clear beats a same-cycle increment
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            pkt_fwd_cnt  <= '0;
            pkt_drop_cnt <= '0;
        end else if (cnt_clr) begin
            pkt_fwd_cnt  <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            if (fwd_inc && (pkt_fwd_cnt != '1))
                pkt_fwd_cnt <= pkt_fwd_cnt + 1'b1;
            if (drop_inc && (pkt_drop_cnt != '1))
                pkt_drop_cnt <= pkt_drop_cnt + 1'b1;
        end
    end

    nf10_axis_reg_slice #(
        .C_DATA_WIDTH  (C_DATA_WIDTH),
        .C_TUSER_WIDTH (C_TUSER_WIDTH)
    ) u_out_reg (
        .clk      (axi_aclk),
        .rst      (axi_reset),
        .s_tdata  (s_axis_tdata),
        .s_tstrb  (s_axis_tstrb),
        .s_tuser  (user_mod),
        .s_tlast  (s_axis_tlast),
        .s_tvalid (emit),
        .s_tready (slice_ready),
        .m_tdata  (m_axis_tdata),
        .m_tstrb  (m_axis_tstrb),
        .m_tuser  (m_axis_tuser),
        .m_tlast  (m_axis_tlast),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_nf10_nic_opl_multi.sv
// Directed and randomized bench for nf10_nic_opl_multi.
// A packet-level model predicts every output beat and counter value.
module tb_nf10_nic_opl_multi;

    localparam int DW = 64;
    localparam int UW = 128;
    localparam int CW = 4;

    typedef struct {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
        logic [UW-1:0]   user;
        logic            last;
    } beat_t;

    logic            clk = 1'b0;
    logic            axi_reset = 1'b1;
    logic [DW-1:0]   s_tdata = '0;
    logic [DW/8-1:0] s_tstrb = '0;
    logic [UW-1:0]   s_tuser = '0;
    logic            s_tvalid = 1'b0;
    logic            s_tready;
    logic            s_tlast = 1'b0;
    logic [DW-1:0]   m_tdata;
    logic [DW/8-1:0] m_tstrb;
    logic [UW-1:0]   m_tuser;
    logic            m_tvalid;
    logic            m_tready = 1'b1;
    logic            m_tlast;
    logic [1:0]      mode = 2'd0;
    logic            cnt_clr = 1'b0;
    logic [CW-1:0]   fwd_cnt;
    logic [CW-1:0]   drop_cnt;

    int checks = 0;
    int failures = 0;
    int rdy_mode = 0;
    bit clr_en = 0;
    int cyc = 0;

    beat_t exp_q[$];
    bit    in_pkt = 0;
    bit    pkt_fwd = 0;
    int    exp_fwd = 0;
    int    exp_drop = 0;
    bit    held = 0;
    beat_t held_b;

    always #5 clk = ~clk;

    nf10_nic_opl_multi #(
        .C_DATA_WIDTH  (DW),
        .C_TUSER_WIDTH (UW),
        .C_NUM_PORTS   (4),
        .C_SRC_POS     (16),
        .C_DST_POS     (24),
        .C_CNT_WIDTH   (CW)
    ) dut (
        .axi_aclk      (clk),
        .axi_reset     (axi_reset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .mode          (mode),
        .cnt_clr       (cnt_clr),
        .pkt_fwd_cnt   (fwd_cnt),
        .pkt_drop_cnt  (drop_cnt)
    );

    task automatic check(input string tag, input logic [UW-1:0] obs,
                         input logic [UW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // destination predicted directly from the port numbering rules
    function automatic bit predict(input logic [1:0] md,
                                   input logic [7:0] src,
                                   output logic [7:0] dst);
        int idx;
        dst = 8'h00;
        if ($countones(src) != 1 || md > 2'd1) return 0;
        idx = 0;
        for (int i = 0; i < 8; i++) if (src[i]) idx = i;
        if (md == 2'd1) dst = src;
        else if (idx % 2 == 0) dst = 8'h01 << (idx + 1);
        else dst = 8'h01 << (idx - 1);
        return 1;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= (1 << CW) - 1) ? v : v + 1;
    endfunction

    task automatic mon_step();
        beat_t b;
        beat_t e;
        logic [7:0] dst;
        bit fin_fwd;
        bit fin_drop;
        if (axi_reset) begin
            exp_q.delete();
            in_pkt = 0;
            held = 0;
            exp_fwd = 0;
            exp_drop = 0;
            return;
        end
        cyc++;
        check("fwd_cnt", UW'(fwd_cnt), UW'(exp_fwd));
        check("drop_cnt", UW'(drop_cnt), UW'(exp_drop));
        b.data = m_tdata;
        b.strb = m_tstrb;
        b.user = m_tuser;
        b.last = m_tlast;
        if (held) begin
            check("hold_valid", UW'(m_tvalid), UW'(1));
            check("hold_user", m_tuser, held_b.user);
            check("hold_data", UW'(m_tdata), UW'(held_b.data));
        end
        held = 0;
        if (m_tvalid && m_tready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_beat observed=%0h expected=none",
                       m_tdata);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_data", UW'(b.data), UW'(e.data));
                check("out_strb", UW'(b.strb), UW'(e.strb));
                check("out_user", b.user, e.user);
                check("out_last", UW'(b.last), UW'(e.last));
            end
        end else if (m_tvalid) begin
            held = 1;
            held_b = b;
        end
        if (in_pkt && !pkt_fwd && s_tvalid)
            check("drop_tready", UW'(s_tready), UW'(1));
        fin_fwd = 0;
        fin_drop = 0;
        if (s_tvalid && s_tready) begin
            e.data = s_tdata;
            e.strb = s_tstrb;
            e.user = s_tuser;
            e.last = s_tlast;
            if (!in_pkt) begin
                pkt_fwd = predict(mode, s_tuser[23:16], dst);
                e.user[31:24] = dst;
                in_pkt = 1;
            end
            if (pkt_fwd) exp_q.push_back(e);
            if (s_tlast) begin
                in_pkt = 0;
                fin_fwd = pkt_fwd;
                fin_drop = !pkt_fwd;
            end
        end
        if (cnt_clr) begin
            exp_fwd = 0;
            exp_drop = 0;
        end else begin
            if (fin_fwd) exp_fwd = sat_inc(exp_fwd);
            if (fin_drop) exp_drop = sat_inc(exp_drop);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [7:0] src, input logic last);
        int n = 0;
        s_tdata = {$urandom, $urandom};
        s_tstrb = 8'($urandom);
        s_tuser = {$urandom, $urandom, $urandom, $urandom};
        s_tuser[23:16] = src;
        s_tlast = last;
        s_tvalid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!s_tready && n < 200);
        checks++;
        assert (n < 200) else begin
            failures++;
            $error("FAIL tready_timeout observed=0 expected=1");
        end
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [1:0] md, input logic [7:0] src,
                            input int len, input int gap);
        mode = md;
        for (int i = 0; i < len; i++) begin
            drive_beat(src, i == len - 1);
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        tick();
        check("drain", UW'(exp_q.size()), UW'(0));
    endtask

    task automatic clear_cnts();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        tick();
    endtask

    initial begin
        int c0;
        int len;
        logic [7:0] src;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
            forever begin
                tick();
                case (rdy_mode)
                    0: m_tready = 1'b1;
                    1: m_tready = !m_tready;
                    default: m_tready = ($urandom_range(0, 3) != 0);
                endcase
                if (clr_en) cnt_clr = ($urandom_range(0, 19) == 0);
            end
        join_none

        repeat (2) tick();
        @(negedge clk);
        check("rst_valid", UW'(m_tvalid), UW'(0));
        check("rst_last", UW'(m_tlast), UW'(0));
        check("rst_user", m_tuser, UW'(0));
        check("rst_fwd", UW'(fwd_cnt), UW'(0));
        axi_reset = 1'b0;
        tick();

        mode = 2'd0;
        drive_beat(8'h01, 1'b0);
        @(negedge clk);
        check("lat_valid", UW'(m_tvalid), UW'(1));
        check("lat_dst", UW'(m_tuser[31:24]), UW'(8'h02));
        tick();
        drive_beat(8'h01, 1'b0);
        drive_beat(8'h01, 1'b1);
        drain();
        check("t1_fwd", UW'(fwd_cnt), UW'(1));

        drive_beat(8'h08, 1'b1);
        @(negedge clk);
        check("t2_dst", UW'(m_tuser[31:24]), UW'(8'h04));
        check("t2_last", UW'(m_tlast), UW'(1));
        drain();
        check("t2_fwd", UW'(fwd_cnt), UW'(2));

        clear_cnts();
        send_pkt(2'd1, 8'h20, 1, 0);
        send_pkt(2'd1, 8'h03, 4, 0);
        drain();
        check("t3_drop", UW'(drop_cnt), UW'(1));
        check("t3_fwd", UW'(fwd_cnt), UW'(1));

        rdy_mode = 1;
        c0 = cyc;
        for (int p = 0; p < 4; p++) send_pkt(2'd0, 8'h04, 2, 0);
        drain();
        check("t4_tput", UW'((cyc - c0) <= 22), UW'(1));
        rdy_mode = 0;

        clear_cnts();
        mode = 2'd0;
        drive_beat(8'h02, 1'b0);
        mode = 2'd2;
        drive_beat(8'h02, 1'b0);
        drive_beat(8'h02, 1'b0);
        drive_beat(8'h02, 1'b1);
        send_pkt(2'd2, 8'h02, 2, 0);
        drain();
        check("t5_fwd", UW'(fwd_cnt), UW'(1));
        check("t5_drop", UW'(drop_cnt), UW'(1));

        clear_cnts();
        for (int p = 0; p < 16; p++) send_pkt(2'd1, 8'h10, 1, 0);
        drain();
        check("sat_fwd", UW'(fwd_cnt), UW'(15));
        mode = 2'd0;
        drive_beat(8'h40, 1'b0);
        cnt_clr = 1'b1;
        drive_beat(8'h40, 1'b1);
        cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_wins", UW'(fwd_cnt), UW'(0));
        drain();

        send_pkt(2'd0, 8'h01, 1, 0);
        drive_beat(8'h01, 1'b0);
        drive_beat(8'h01, 1'b0);
        axi_reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", UW'(m_tvalid), UW'(0));
        check("mid_rst_cnt", UW'(fwd_cnt), UW'(0));
        tick();
        axi_reset = 1'b0;
        tick();
        send_pkt(2'd0, 8'h04, 1, 0);
        drain();
        check("post_rst_fwd", UW'(fwd_cnt), UW'(1));

        rdy_mode = 2;
        clr_en = 1;
        for (int p = 0; p < 150; p++) begin
            if ($urandom_range(0, 9) < 7)
                src = 8'h01 << $urandom_range(0, 7);
            else
                src = 8'($urandom);
            len = $urandom_range(1, 4);
            send_pkt(2'($urandom_range(0, 3)), src, len,
                     $urandom_range(0, 1));
        end
        clr_en = 0;
        cnt_clr = 1'b0;
        rdy_mode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
